ins_fetch: RTL and testbench
============================

// Module: ins_fetch
// PURPOSE
//  Instruction fetch initiator. Drives the read side of the instruction memory (1-cycle registered
//  read latency, output gated by read-enable), buffers returned words in a small FIFO and hands
//  {instruction, PC} to decode over a valid/ready handshake. Handles branch redirect and halt.
// PARAMETERS
//  ADDR_WIDTH  10    byte-address width; must equal the instruction memory's ADDR_WIDTH
//  RESET_PC    0     byte address fetched first after reset; bits [1:0] must be 0
//  FIFO_DEPTH  2     instruction buffer entries; power of 2, >=2
// PORTS
//  INS_FETCH_Clk          in   1           clock, all logic on rising edge
//  INS_FETCH_Reset        in   1           synchronous, active-high reset
//  INS_FETCH_Redirect     in   1           flush and restart fetch at Redirect_Pc
//  INS_FETCH_Redirect_Pc  in   ADDR_WIDTH  redirect target (byte address; bits [1:0] ignored)
//  INS_FETCH_Halt         in   1           level: stop issuing new fetches
//  INS_FETCH_Mem_Re       out  1           read enable to instruction memory
//  INS_FETCH_Mem_Address  out  ADDR_WIDTH  byte address to instruction memory
//  INS_FETCH_Mem_Data     in   32          memory read data, valid 1 cycle after address
//  INS_FETCH_Ins_Valid    out  1           Ins/Ins_Pc hold a valid entry
//  INS_FETCH_Ins          out  32          instruction word (FIFO head)
//  INS_FETCH_Ins_Pc       out  ADDR_WIDTH  byte address of Ins
//  INS_FETCH_Ins_Ready    in   1           decode accepts head when Valid & Ready
// BEHAVIOUR
//  Reset (sync, highest priority): state=RUN, pc_q=RESET_PC, FIFO empty, in-flight=0, kill=0;
//   outputs Mem_Re=0, Mem_Address=RESET_PC, Ins_Valid=0, Ins=0, Ins_Pc=0.
//  FSM: RUN (issue allowed) / HALT (no issue). RUN->HALT when Halt=1; HALT->RUN when Halt=0.
//   The transition takes effect the cycle after Halt changes.
//  Mem_Address = pc_q (registered); low 2 bits always 0.
//  issue = (state==RUN) & ~Redirect & ((count + inflight - pop) < FIFO_DEPTH).
//   pop = Ins_Valid & Ins_Ready.
//  On issue: inflight<=1, pc_q <= pc_q+4 (mod 2**ADDR_WIDTH; wraps to 0 with no error).
//   Otherwise inflight<=0.
//  Mem_Re = issue | inflight. Re must stay 1 in the data cycle because memory output is gated by Re.
//  Response: the cycle after an issue, Mem_Data is written to the FIFO with its PC,
//   unless kill=1 (then discarded). Ins_Valid rises the following cycle.
//  Latency: issue at cycle N -> Ins_Valid=1 at N+2. Sustains 1 instr/cycle with Ready held high.
//  FIFO full: no issue; the pop-relief term allows issue in the same cycle as a pop.
//   Overflow is impossible by construction; an assertion checks it.
//  FIFO empty: Ins_Valid=0; Ins/Ins_Pc hold their last value. Decode must ignore them.
//  Redirect (priority over issue and Halt):
//   - flush FIFO (Ins_Valid=0 next cycle); any pop in the same cycle is ignored
//   - kill<=inflight, so a response arriving next cycle is dropped
//   - pc_q <= {Redirect_Pc[ADDR_WIDTH-1:2],2'b00}
//   - no issue in the redirect cycle; state is unchanged
//   - in RUN, first redirected instr is valid 3 cycles after the Redirect cycle
//  Back-to-back Redirects: the last one wins; each flushes again.
//  Halt mid-operation: in-flight response still completes into the FIFO; buffered entries still drain.
//   Mem_Re drops once inflight=0. No instructions are lost.
//  Redirect during HALT: updates pc_q and flushes; fetch resumes at the new PC when Halt drops.
//  Reset mid-operation: all state discarded in the reset cycle; in-flight data ignored.
// CONFIGURATION
//  INS_FETCH_PERF_EN defined: adds two 32-bit output ports, reset to 0, saturating at 32'hFFFFFFFF:
//   - INS_FETCH_Fetch_Count: increments on every pop
//   - INS_FETCH_Stall_Count: increments on every cycle with Ins_Valid & ~Ins_Ready
//  INS_FETCH_PERF_EN undefined: neither port nor counter logic exists; core behaviour is identical.
// TESTING
//  1) Reset, mem[i]=i+1, Ready=1 -> Mem_Address 0,4,8.. from cycle 1.
//     Ins=1,2,3.. with Ins_Pc=0,4,8.. from cycle 3; Valid stays continuous.
//  2) Ready=0 for 5 cycles after first valid -> exactly FIFO_DEPTH entries buffered, issue stops.
//     Ready=1 -> sequence continues with no gaps or duplicates.
//  3) Redirect=1, Redirect_Pc=0x103 while streaming -> in-flight word dropped.
//     3 cycles later Ins_Pc=0x100 with Ins=mem[0x40].
//  4) Halt=1 mid-stream -> Mem_Re falls within 2 cycles and buffered words drain in order.
//     Halt=0 -> fetch resumes at next sequential PC.
//  5) RESET_PC=0x3F8, ADDR_WIDTH=10 -> Ins_Pc sequence 0x3F8, 0x3FC, 0x000, 0x004.
//  6) With INS_FETCH_PERF_EN: 10 pops plus 4 stalled cycles -> Fetch_Count=10, Stall_Count=4.
//     Reset -> both counters return to 0.

Source files
------------

// File: rtl/ins_fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the {instruction, PC} handshake to decode.
// master = fetch unit, slave = memory/decode side.
interface ins_fetch_if #(
   parameter int ADDR_WIDTH = 10
) ();
   logic                  INS_FETCH_Mem_Re;
   logic [ADDR_WIDTH-1:0] INS_FETCH_Mem_Address;
   logic [31:0]           INS_FETCH_Mem_Data;
   logic                  INS_FETCH_Ins_Valid;
   logic [31:0]           INS_FETCH_Ins;
   logic [ADDR_WIDTH-1:0] INS_FETCH_Ins_Pc;
   logic                  INS_FETCH_Ins_Ready;

   modport master (
      output INS_FETCH_Mem_Re,
      output INS_FETCH_Mem_Address,
      input  INS_FETCH_Mem_Data,
      output INS_FETCH_Ins_Valid,
      output INS_FETCH_Ins,
      output INS_FETCH_Ins_Pc,
      input  INS_FETCH_Ins_Ready
   );

   modport slave (
      input  INS_FETCH_Mem_Re,
      input  INS_FETCH_Mem_Address,
      output INS_FETCH_Mem_Data,
      input  INS_FETCH_Ins_Valid,
      input  INS_FETCH_Ins,
      input  INS_FETCH_Ins_Pc,
      output INS_FETCH_Ins_Ready
   );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch initiator: sequential PC fetch, small response FIFO, redirect/halt control.
// Optional perf counters are enabled by defining INS_FETCH_PERF_EN.
module ins_fetch #(
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  INS_FETCH_Clk,
   input  logic                  INS_FETCH_Reset,
   input  logic                  INS_FETCH_Redirect,
   input  logic [ADDR_WIDTH-1:0] INS_FETCH_Redirect_Pc,
   input  logic                  INS_FETCH_Halt,
`ifdef INS_FETCH_PERF_EN
   output logic [31:0]           INS_FETCH_Fetch_Count,
   output logic [31:0]           INS_FETCH_Stall_Count,
`endif
   output logic                  o_dbg_halted,
   ins_fetch_if.master           bus
);
   // Handshake: decode takes the head entry on any cycle with Ins_Valid & Ins_Ready.
   // Ins_Valid never depends on Ins_Ready; Ins/Ins_Pc are meaningless while Ins_Valid=0.

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_inflight_pc;
   logic                  r_inflight;
   logic                  r_kill;
   logic [31:0]           r_fifo_ins [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_pc  [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic [31:0]           r_hold_ins;
   logic [ADDR_WIDTH-1:0] r_hold_pc;

   logic                  w_valid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic [CW:0]           w_occ;
   logic [31:0]           w_ins_out;
   logic [ADDR_WIDTH-1:0] w_pc_out;

   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & bus.INS_FETCH_Ins_Ready;

   // Occupancy once this cycle's pop and the outstanding response are accounted for.
   assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign w_issue = ~INS_FETCH_Reset & (r_state == ST_RUN) & ~INS_FETCH_Redirect &
                    (w_occ < (CW+1)'(FIFO_DEPTH));

   // A response landing in a redirect cycle belongs to the old stream.
   assign w_push  = r_inflight & ~r_kill & ~INS_FETCH_Redirect;

   // When empty, present the last value shown rather than a stale FIFO slot.
   assign w_ins_out = w_valid ? r_fifo_ins[r_rd_ptr] : r_hold_ins;
   assign w_pc_out  = w_valid ? r_fifo_pc[r_rd_ptr]  : r_hold_pc;

   assign bus.INS_FETCH_Mem_Re      = ~INS_FETCH_Reset & (w_issue | r_inflight);
   assign bus.INS_FETCH_Mem_Address = r_pc;
   assign bus.INS_FETCH_Ins_Valid   = w_valid;
   assign bus.INS_FETCH_Ins         = w_ins_out;
   assign bus.INS_FETCH_Ins_Pc      = w_pc_out;
   assign o_dbg_halted              = (r_state == ST_HALT);

   always_ff @(posedge INS_FETCH_Clk) begin
      if (INS_FETCH_Reset) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_inflight_pc <= RESET_PC;
         r_inflight    <= 1'b0;
         r_kill        <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_hold_ins    <= '0;
         r_hold_pc     <= '0;
      end else begin
         r_hold_ins <= w_ins_out;
         r_hold_pc  <= w_pc_out;
         if (INS_FETCH_Redirect) begin
            r_pc       <= {INS_FETCH_Redirect_Pc[ADDR_WIDTH-1:2], 2'b00};
            r_kill     <= r_inflight;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
         end else begin
            r_state    <= INS_FETCH_Halt ? ST_HALT : ST_RUN;
            r_kill     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
               r_pc          <= r_pc + ADDR_WIDTH'(4);
               r_inflight_pc <= r_pc;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge INS_FETCH_Clk) begin
      if (!INS_FETCH_Reset && w_push) begin
         r_fifo_ins[r_wr_ptr] <= bus.INS_FETCH_Mem_Data;
         r_fifo_pc[r_wr_ptr]  <= r_inflight_pc;
      end
   end

`ifdef INS_FETCH_PERF_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge INS_FETCH_Clk) begin
      if (INS_FETCH_Reset) begin
         r_fetch_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_pop && (r_fetch_count != 32'hFFFF_FFFF))
            r_fetch_count <= r_fetch_count + 32'd1;
         if (w_valid && !bus.INS_FETCH_Ins_Ready && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign INS_FETCH_Fetch_Count = r_fetch_count;
   assign INS_FETCH_Stall_Count = r_stall_count;
`endif

   // Issue throttling must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge INS_FETCH_Clk) disable iff (INS_FETCH_Reset)
      (w_push && !w_pop) |-> (r_count < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: cycle table for streaming/backpressure/redirect, hand sequences for halt,
// randomized traffic checked against an in-order PC stream model, and a wrap-around instance.
module tb_ins_fetch;
   logic clk;
   logic rst;
   logic redirect;
   logic [9:0] redirect_pc;
   logic halt;
   logic dbg_halted;
   logic dbg_halted2;

   int checks;
   int errors;

   ins_fetch_if #(.ADDR_WIDTH(10)) bus  ();
   ins_fetch_if #(.ADDR_WIDTH(10)) bus2 ();

`ifdef INS_FETCH_PERF_EN
   logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

   ins_fetch #(.ADDR_WIDTH(10), .RESET_PC(10'h000), .FIFO_DEPTH(2)) dut (
      .INS_FETCH_Clk         (clk),
      .INS_FETCH_Reset       (rst),
      .INS_FETCH_Redirect    (redirect),
      .INS_FETCH_Redirect_Pc (redirect_pc),
      .INS_FETCH_Halt        (halt),
`ifdef INS_FETCH_PERF_EN
      .INS_FETCH_Fetch_Count (fetch_count),
      .INS_FETCH_Stall_Count (stall_count),
`endif
      .o_dbg_halted          (dbg_halted),
      .bus                   (bus)
   );

   ins_fetch #(.ADDR_WIDTH(10), .RESET_PC(10'h3F8), .FIFO_DEPTH(2)) dut_wrap (
      .INS_FETCH_Clk         (clk),
      .INS_FETCH_Reset       (rst),
      .INS_FETCH_Redirect    (1'b0),
      .INS_FETCH_Redirect_Pc (10'h000),
      .INS_FETCH_Halt        (1'b0),
`ifdef INS_FETCH_PERF_EN
      .INS_FETCH_Fetch_Count (fetch_count2),
      .INS_FETCH_Stall_Count (stall_count2),
`endif
      .o_dbg_halted          (dbg_halted2),
      .bus                   (bus2)
   );

   // Clock and memory models: 1-cycle registered read, output gated by read enable.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   logic [31:0] rd1, rd2;

   always @(posedge clk) begin
      if (bus.INS_FETCH_Mem_Re)  rd1 <= mem[bus.INS_FETCH_Mem_Address[9:2]];
      if (bus2.INS_FETCH_Mem_Re) rd2 <= mem[bus2.INS_FETCH_Mem_Address[9:2]];
   end
   assign bus.INS_FETCH_Mem_Data  = bus.INS_FETCH_Mem_Re  ? rd1 : 32'h0;
   assign bus2.INS_FETCH_Mem_Data = bus2.INS_FETCH_Mem_Re ? rd2 : 32'h0;
   assign bus2.INS_FETCH_Ins_Ready = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: accepted instructions form one in-order PC stream from the reset PC,
   // restarted at the aligned target by each redirect; every word equals mem[pc/4].
   logic [9:0] exp_q [$];
   logic [9:0] m_exp_pc;
   logic [1:0] m_halt_h;
   logic [1:0] m_redir_h;
   int         m_pops;

   always @(negedge clk) begin
      if (rst) begin
         m_exp_pc  = 10'h000;
         m_halt_h  = 2'b00;
         m_redir_h = 2'b00;
      end else begin
         chk("addr_align", {30'd0, bus.INS_FETCH_Mem_Address[1:0]}, 32'd0);
         if (bus.INS_FETCH_Ins_Valid && bus.INS_FETCH_Ins_Ready) begin
            chk("pop_pc",  {22'd0, bus.INS_FETCH_Ins_Pc}, {22'd0, m_exp_pc});
            chk("pop_ins", bus.INS_FETCH_Ins, mem[m_exp_pc[9:2]]);
            m_exp_pc = m_exp_pc + 10'd4;
            m_pops++;
         end
         if (redirect) m_exp_pc = {redirect_pc[9:2], 2'b00};
         // Halted for two cycles with no redirect two cycles back: nothing may be outstanding.
         if (m_halt_h == 2'b11 && !m_redir_h[1])
            chk("halt_re_low", {31'd0, bus.INS_FETCH_Mem_Re}, 32'd0);
         m_halt_h  = {m_halt_h[0], halt};
         m_redir_h = {m_redir_h[0], redirect};
      end
   end

   // Wrap-around instance: first four accepted PCs after every reset.
   int n2;
   always @(negedge clk) begin
      if (rst) begin
         n2 = 0;
         exp_q = {10'h3F8, 10'h3FC, 10'h000, 10'h004};
      end else if (bus2.INS_FETCH_Ins_Valid && n2 < 4) begin
         chk("wrap_pc",  {22'd0, bus2.INS_FETCH_Ins_Pc}, {22'd0, exp_q[0]});
         chk("wrap_ins", bus2.INS_FETCH_Ins, mem[exp_q[0][9:2]]);
         void'(exp_q.pop_front());
         n2++;
      end
   end

   task automatic do_reset(input bit rand_mem);
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 10'h000;
      halt = 1'b0;
      bus.INS_FETCH_Ins_Ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = rand_mem ? $urandom : 32'(i + 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_re",    {31'd0, bus.INS_FETCH_Mem_Re}, 32'd0);
      chk("rst_addr",  {22'd0, bus.INS_FETCH_Mem_Address}, 32'h000);
      chk("rst_addr2", {22'd0, bus2.INS_FETCH_Mem_Address}, 32'h3F8);
      chk("rst_valid", {31'd0, bus.INS_FETCH_Ins_Valid}, 32'd0);
      chk("rst_ins",   bus.INS_FETCH_Ins, 32'd0);
      chk("rst_pc",    {22'd0, bus.INS_FETCH_Ins_Pc}, 32'd0);
      chk("rst_state", {31'd0, dbg_halted}, 32'd0);
`ifdef INS_FETCH_PERF_EN
      chk("rst_fetch_cnt", fetch_count, 32'd0);
      chk("rst_stall_cnt", stall_count, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        ready;
      logic        redir;
      logic [9:0]  rpc;
      logic        e_re;
      logic [9:0]  e_addr;
      logic        e_valid;
      logic [31:0] e_ins;
      logic [9:0]  e_pc;
   } vec_t;

   vec_t vecs [19];
   bit   got;
   int   pops0;
   logic [9:0] first_pc;

   initial begin
      #500000;
      errors++;
      $display("FAIL global_timeout actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      checks = 0;
      errors = 0;
      m_pops = 0;
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 10'h000;
      halt = 1'b0;
      bus.INS_FETCH_Ins_Ready = 1'b0;

      // Cycle table starting at the first cycle out of reset (mem[i] = i+1, FIFO_DEPTH = 2).
      vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h000, 1'b0, 32'h0,  10'h000};
      vecs[1]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h004, 1'b0, 32'h0,  10'h000};
      vecs[2]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h008, 1'b1, 32'h1,  10'h000};
      vecs[3]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h00C, 1'b1, 32'h2,  10'h004};
      vecs[4]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h010, 1'b1, 32'h3,  10'h008};
      vecs[5]  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[6]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[7]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[10] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h014, 1'b1, 32'h4,  10'h00C};
      vecs[11] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h018, 1'b1, 32'h5,  10'h010};
      vecs[12] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h01C, 1'b1, 32'h6,  10'h014};
      vecs[13] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h020, 1'b1, 32'h7,  10'h018};
      vecs[14] = '{1'b1, 1'b1, 10'h103, 1'b1, 10'h024, 1'b1, 32'h8,  10'h01C};
      vecs[15] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h100, 1'b0, 32'h0,  10'h000};
      vecs[16] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h104, 1'b0, 32'h0,  10'h000};
      vecs[17] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h108, 1'b1, 32'h41, 10'h100};
      vecs[18] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h10C, 1'b1, 32'h42, 10'h104};

      next_cycle();
      do_reset(1'b0);

      for (int k = 0; k < 19; k++) begin
         bus.INS_FETCH_Ins_Ready = vecs[k].ready;
         redirect    = vecs[k].redir;
         redirect_pc = vecs[k].rpc;
         @(negedge clk);
         chk($sformatf("c%0d_re", k + 1),    {31'd0, bus.INS_FETCH_Mem_Re}, {31'd0, vecs[k].e_re});
         chk($sformatf("c%0d_addr", k + 1),  {22'd0, bus.INS_FETCH_Mem_Address}, {22'd0, vecs[k].e_addr});
         chk($sformatf("c%0d_valid", k + 1), {31'd0, bus.INS_FETCH_Ins_Valid}, {31'd0, vecs[k].e_valid});
         if (vecs[k].e_valid) begin
            chk($sformatf("c%0d_ins", k + 1), bus.INS_FETCH_Ins, vecs[k].e_ins);
            chk($sformatf("c%0d_pc", k + 1),  {22'd0, bus.INS_FETCH_Ins_Pc}, {22'd0, vecs[k].e_pc});
         end
         next_cycle();
      end
      redirect = 1'b0;
      chk("wrap_seen", 32'(n2), 32'd4);

      // Halt mid-stream: read enable drops within two cycles, buffer drains, then resume.
      halt = 1'b1;
      bus.INS_FETCH_Ins_Ready = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("halt_re_2cyc", {31'd0, bus.INS_FETCH_Mem_Re}, 32'd0);
      chk("halt_state",   {31'd0, dbg_halted}, 32'd1);
      next_cycle();
      for (int k = 0; k < 8 && bus.INS_FETCH_Ins_Valid; k++) next_cycle();
      @(negedge clk);
      chk("halt_drained", {31'd0, bus.INS_FETCH_Ins_Valid}, 32'd0);
      next_cycle();
      halt = 1'b0;
      got = 1'b0;
      first_pc = 10'h000;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (bus.INS_FETCH_Ins_Valid) begin
            got = 1'b1;
            first_pc = bus.INS_FETCH_Ins_Pc;
         end
         next_cycle();
      end
      chk("resume_seen", {31'd0, got}, 32'd1);
      chk("resume_pc", {22'd0, first_pc}, 32'h114);

      // Redirect while halted: no fetch until Halt drops, then restart at the aligned target.
      halt = 1'b1;
      for (int k = 0; k < 4; k++) next_cycle();
      redirect = 1'b1;
      redirect_pc = 10'h2A6;
      next_cycle();
      redirect = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("hr_valid", {31'd0, bus.INS_FETCH_Ins_Valid}, 32'd0);
      chk("hr_re",    {31'd0, bus.INS_FETCH_Mem_Re}, 32'd0);
      chk("hr_addr",  {22'd0, bus.INS_FETCH_Mem_Address}, 32'h2A4);
      next_cycle();
      halt = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (bus.INS_FETCH_Ins_Valid) begin
            got = 1'b1;
            chk("hr_pc",  {22'd0, bus.INS_FETCH_Ins_Pc}, 32'h2A4);
            chk("hr_ins", bus.INS_FETCH_Ins, 32'hAA);
         end
         next_cycle();
      end
      chk("hr_seen", {31'd0, got}, 32'd1);

      // Randomized traffic with random memory contents.
      do_reset(1'b1);
      pops0 = m_pops;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            redirect = 1'b0;
         end else begin
            rst = 1'b0;
            redirect = ($urandom_range(0, 24) == 0);
            redirect_pc = 10'($urandom);
         end
         if ($urandom_range(0, 11) == 0) halt = ~halt;
         bus.INS_FETCH_Ins_Ready = ($urandom_range(0, 3) != 0);
         next_cycle();
      end
      rst = 1'b0;
      redirect = 1'b0;
      halt = 1'b0;
      bus.INS_FETCH_Ins_Ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = bus.INS_FETCH_Ins_Valid;
         next_cycle();
      end
      chk("rand_live", {31'd0, got}, 32'd1);
      chk("rand_progress", {31'd0, (m_pops - pops0) > 500}, 32'd1);

`ifdef INS_FETCH_PERF_EN
      begin
         int stalls;
         int pops;
         do_reset(1'b0);
         stalls = 0;
         pops = 0;
         for (int k = 0; k < 200 && pops < 10; k++) begin
            if (bus.INS_FETCH_Ins_Valid) begin
               if (stalls < 4) begin
                  bus.INS_FETCH_Ins_Ready = 1'b0;
                  stalls++;
               end else begin
                  bus.INS_FETCH_Ins_Ready = 1'b1;
                  pops++;
               end
            end else begin
               bus.INS_FETCH_Ins_Ready = 1'b0;
            end
            next_cycle();
         end
         bus.INS_FETCH_Ins_Ready = 1'b0;
         @(negedge clk);
         chk("perf_fetch", fetch_count, 32'd10);
         chk("perf_stall", stall_count, 32'd4);
         next_cycle();
         do_reset(1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
